// File: rtl/fractal_pkg.sv
// Shared types and constants for the fractal stream framer.
// Holds the FSM state enum, the output beat layout and the buffer depths.
package fractal_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [7:0] tdata;
    logic       tuser;
    logic       tlast;
  } beat_t;

  localparam int FIFO_DEPTH = 16;
  localparam int SKID_DEPTH = 2;
  localparam int BEAT_BITS  = $bits(beat_t);

endpackage

// File: rtl/fractal_stream_fifo.sv
// Buffer between pixel acceptance and the AXI4-Stream output.
// DEPTH == 2 builds a skid buffer with a registered write-ready and one cycle
// of latency; any other DEPTH builds a circular FIFO followed by an output
// register, giving two cycles of latency.
module fractal_stream_fifo #(
  parameter int DEPTH = 2,
  parameter int DW    = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_wr_en,
  input  logic [DW-1:0] i_wr_data,
  output logic          o_wr_ready,
  output logic          o_rd_valid,
  output logic [DW-1:0] o_rd_data,
  input  logic          i_rd_ready
);

  generate
    if (DEPTH == 2) begin : g_skid
      logic          r_main_valid;
      logic          r_skid_valid;
      logic          r_ready;
      logic [DW-1:0] r_main_data;
      logic [DW-1:0] r_skid_data;
      logic          w_take;

      assign w_take = !r_main_valid || i_rd_ready;

      // Main register feeds the output; the skid register catches the one
      // beat that arrives while the output is stalled, and ready drops then.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_main_valid <= 1'b0;
          r_skid_valid <= 1'b0;
          r_ready      <= 1'b0;
          r_main_data  <= '0;
          r_skid_data  <= '0;
        end else if (w_take) begin
          r_ready <= 1'b1;
          if (r_skid_valid) begin
            r_main_valid <= 1'b1;
            r_main_data  <= r_skid_data;
            r_skid_valid <= 1'b0;
          end else begin
            r_main_valid <= i_wr_en;
            if (i_wr_en) r_main_data <= i_wr_data;
          end
        end else if (i_wr_en) begin
          r_skid_valid <= 1'b1;
          r_skid_data  <= i_wr_data;
          r_ready      <= 1'b0;
        end else begin
          r_ready <= !r_skid_valid;
        end
      end

      assign o_wr_ready = r_ready;
      assign o_rd_valid = r_main_valid;
      assign o_rd_data  = r_main_data;
    end else begin : g_fifo
      localparam int PW = $clog2(DEPTH);
      localparam int CW = $clog2(DEPTH + 1);

      logic [DW-1:0] r_mem [DEPTH];
      logic [PW-1:0] r_wr_ptr;
      logic [PW-1:0] r_rd_ptr;
      logic [CW-1:0] r_count;
      logic          r_out_valid;
      logic [DW-1:0] r_out_data;
      logic          w_load;

      assign w_load = (r_count != '0) && (!r_out_valid || i_rd_ready);

      // Storage array, written only when the framer has seen room.
      always_ff @(posedge i_clk) begin
        if (i_wr_en) r_mem[r_wr_ptr] <= i_wr_data;
      end

      // Pointer/occupancy tracking and the output register refill.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_wr_ptr    <= '0;
          r_rd_ptr    <= '0;
          r_count     <= '0;
          r_out_valid <= 1'b0;
          r_out_data  <= '0;
        end else begin
          if (i_wr_en) r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
          if (w_load)  r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);
          r_count <= r_count + CW'(i_wr_en) - CW'(w_load);
          if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= r_mem[r_rd_ptr];
          end else if (i_rd_ready) begin
            r_out_valid <= 1'b0;
          end
        end
      end

      assign o_wr_ready = (r_count != CW'(DEPTH));
      assign o_rd_valid = r_out_valid;
      assign o_rd_data  = r_out_data;
    end
  endgenerate

endmodule

// File: rtl/fractal_stream_framer.sv
// Frames a stream of fractal iteration values into AXI4-Stream video with
// tuser on the first pixel of a frame and tlast on the last pixel of a line.
// Define FRACTAL_FRAMER_FIFO_EN to buffer through a 16-entry FIFO instead of
// the default 2-entry skid buffer.
module fractal_stream_framer
  import fractal_pkg::*;
#(
  parameter int X_BITS = 11,
  parameter int Y_BITS = 11
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              enable,
  input  logic [X_BITS-1:0] cfg_width,
  input  logic [Y_BITS-1:0] cfg_height,
  input  logic              s_pix_tvalid,
  input  logic [7:0]        s_pix_tdata,
  output logic              s_pix_tready,
  output logic              m_axis_tvalid,
  output logic [7:0]        m_axis_tdata,
  output logic              m_axis_tstrb,
  output logic              m_axis_tuser,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic              busy,
  output logic              frame_done
);

`ifdef FRACTAL_FRAMER_FIFO_EN
  localparam int BUF_DEPTH = FIFO_DEPTH;
`else
  localparam int BUF_DEPTH = SKID_DEPTH;
`endif
  localparam int WORD_BITS = BEAT_BITS + 1;

  state_t                r_state;
  logic [X_BITS-1:0]     r_x;
  logic [Y_BITS-1:0]     r_y;
  logic [X_BITS-1:0]     r_width;
  logic [Y_BITS-1:0]     r_height;
  logic                  r_frame_done;

  logic                  w_start_ok;
  logic                  w_accept;
  logic                  w_x_last;
  logic                  w_y_last;
  logic                  w_buf_ready;
  logic                  w_out_eof;
  beat_t                 w_in_beat;
  beat_t                 w_out_beat;
  logic [WORD_BITS-1:0]  w_in_word;
  logic [WORD_BITS-1:0]  w_out_word;

  assign w_start_ok = enable && (cfg_width != '0) && (cfg_height != '0);
  assign w_accept   = s_pix_tvalid && s_pix_tready;
  assign w_x_last   = (r_x == r_width - X_BITS'(1));
  assign w_y_last   = (r_y == r_height - Y_BITS'(1));

  assign w_in_beat = '{tdata: s_pix_tdata,
                       tuser: (r_x == '0) && (r_y == '0),
                       tlast: w_x_last};
  // The extra top bit marks the final pixel of the frame so frame_done can be
  // raised when that beat leaves, independent of any relatched geometry.
  assign w_in_word = {w_x_last && w_y_last, w_in_beat};
  assign {w_out_eof, w_out_beat} = w_out_word;

  // Frame FSM with column/row counters; geometry is latched at frame start.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state  <= ST_IDLE;
      r_x      <= '0;
      r_y      <= '0;
      r_width  <= '0;
      r_height <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start_ok) begin
            r_state  <= ST_RUN;
            r_width  <= cfg_width;
            r_height <= cfg_height;
          end
        end
        ST_RUN: begin
          if (w_accept) begin
            if (w_x_last) begin
              r_x <= '0;
              if (w_y_last) begin
                r_y <= '0;
                if (w_start_ok) begin
                  r_width  <= cfg_width;
                  r_height <= cfg_height;
                end else begin
                  r_state <= ST_IDLE;
                end
              end else begin
                r_y <= r_y + Y_BITS'(1);
              end
            end else begin
              r_x <= r_x + X_BITS'(1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // One-cycle pulse after the end-of-frame beat completes its handshake.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_frame_done <= 1'b0;
    else          r_frame_done <= m_axis_tvalid && m_axis_tready && w_out_eof;
  end

  fractal_stream_fifo #(
    .DEPTH (BUF_DEPTH),
    .DW    (WORD_BITS)
  ) u_buf (
    .i_clk      (aclk),
    .i_rst_n    (aresetn),
    .i_wr_en    (w_accept),
    .i_wr_data  (w_in_word),
    .o_wr_ready (w_buf_ready),
    .o_rd_valid (m_axis_tvalid),
    .o_rd_data  (w_out_word),
    .i_rd_ready (m_axis_tready)
  );

  assign s_pix_tready = (r_state == ST_RUN) && w_buf_ready;
  assign busy         = (r_state == ST_RUN);
  assign frame_done   = r_frame_done;
  assign m_axis_tdata = w_out_beat.tdata;
  assign m_axis_tuser = w_out_beat.tuser;
  assign m_axis_tlast = w_out_beat.tlast;
  assign m_axis_tstrb = 1'b1;

endmodule

// File: tb/tb_fractal_stream_framer.sv
// Self-checking bench for fractal_stream_framer. The driver pushes the
// expected beat for every accepted pixel; the collector records every output
// cycle and each test walks those records against the expected queue.
module tb_fractal_stream_framer;

`ifdef FRACTAL_FRAMER_FIFO_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [7:0] d;
    logic       u;
    logic       l;
    logic       eof;
  } exp_t;

  typedef struct {
    logic       v;
    logic       r;
    logic [7:0] d;
    logic       u;
    logic       l;
    logic       done;
  } cyc_t;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b1;
  logic        enable = 1'b0;
  logic [10:0] cfg_width = '0;
  logic [10:0] cfg_height = '0;
  logic        s_pix_tvalid = 1'b0;
  logic [7:0]  s_pix_tdata = '0;
  logic        s_pix_tready;
  logic        m_axis_tvalid;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tstrb;
  logic        m_axis_tuser;
  logic        m_axis_tlast;
  logic        m_axis_tready = 1'b1;
  logic        busy;
  logic        frame_done;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  cyc_t cyc_q[$];
  time  t_acc = 0;
  time  t_first_v = 0;

  fractal_stream_framer dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .enable        (enable),
    .cfg_width     (cfg_width),
    .cfg_height    (cfg_height),
    .s_pix_tvalid  (s_pix_tvalid),
    .s_pix_tdata   (s_pix_tdata),
    .s_pix_tready  (s_pix_tready),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tstrb  (m_axis_tstrb),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .busy          (busy),
    .frame_done    (frame_done)
  );

  always #5 aclk = ~aclk;

  task automatic reset_dut();
    aresetn = 1'b0;
    enable = 1'b0;
    s_pix_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    exp_q.delete();
    cyc_q.delete();
    t_acc = 0;
    t_first_v = 0;
  endtask

  // Drives n pixels of a w x h frame; act 1 drops enable and act 2 shrinks
  // cfg_width to 2 once act_at pixels have been accepted.
  task automatic drive(input int w, input int h, input int n, input int act_at,
                       input int act, input bit gap, input int base);
    int   k = 0;
    int   cyc = 0;
    int   idx;
    exp_t e;
    while (k < n && cyc < 3000) begin
      s_pix_tvalid = gap ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_pix_tdata  = 8'(base + k);
      @(negedge aclk);
      if (s_pix_tvalid && s_pix_tready) begin
        idx   = k % (w * h);
        e.d   = s_pix_tdata;
        e.u   = (idx == 0);
        e.l   = ((idx % w) == w - 1);
        e.eof = (idx == w * h - 1);
        exp_q.push_back(e);
        if (t_acc == 0) t_acc = $time;
        k++;
      end
      @(posedge aclk);
      #1;
      if (k == act_at && act == 1) enable = 1'b0;
      if (k == act_at && act == 2) cfg_width = 11'd2;
      cyc++;
    end
    s_pix_tvalid = 1'b0;
  endtask

  // Records every output cycle until n handshakes plus two trailing cycles.
  task automatic collect(input int n, input bit toggle);
    int   hs = 0;
    int   extra = 0;
    int   cyc = 0;
    cyc_t c;
    cyc_q.delete();
    while (extra < 2 && cyc < 3000) begin
      @(posedge aclk);
      #1;
      m_axis_tready = toggle ? ((cyc % 2) == 0) : 1'b1;
      @(negedge aclk);
      c.v = m_axis_tvalid;
      c.r = m_axis_tready;
      c.d = m_axis_tdata;
      c.u = m_axis_tuser;
      c.l = m_axis_tlast;
      c.done = frame_done;
      cyc_q.push_back(c);
      if (c.v === 1'b1 && t_first_v == 0) t_first_v = $time;
      if (hs >= n) extra++;
      else if (c.v === 1'b1 && c.r === 1'b1) hs++;
      cyc++;
    end
    m_axis_tready = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    aresetn = 1'b0;
    #1;
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_tvalid: got %b want 0", m_axis_tvalid); end
    checks++; if (m_axis_tdata !== 8'd0) begin errors++; $display("[TB] FAIL reset_tdata: got %0d want 0", m_axis_tdata); end
    checks++; if ({m_axis_tuser, m_axis_tlast} !== 2'b00) begin errors++; $display("[TB] FAIL reset_user_last: got %b want 00", {m_axis_tuser, m_axis_tlast}); end
    checks++; if (s_pix_tready !== 1'b0) begin errors++; $display("[TB] FAIL reset_s_tready: got %b want 0", s_pix_tready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_done: got %b want 0", frame_done); end
    checks++; if (m_axis_tstrb !== 1'b1) begin errors++; $display("[TB] FAIL reset_tstrb: got %b want 1", m_axis_tstrb); end
    reset_dut();
  endtask

  task automatic test_basic();
    int hs = 0, first_hs = -1, last_hs = -1;
    logic prev_eof = 1'b0;
    exp_t e;
    reset_dut();
    cfg_width = 11'd4; cfg_height = 11'd2; enable = 1'b1;
    fork
      drive(4, 2, 8, -1, 0, 1'b0, 0);
      collect(8, 1'b0);
    join
    foreach (cyc_q[i]) begin
      checks++;
      if (cyc_q[i].done !== prev_eof) begin errors++; $display("[TB] FAIL basic_frame_done cycle %0d: got %b want %b", i, cyc_q[i].done, prev_eof); end
      prev_eof = 1'b0;
      if (cyc_q[i].v === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("[TB] FAIL basic_extra_beat: got data %0d want none", cyc_q[i].d); end
        else begin
          e = exp_q[0];
          if ({cyc_q[i].d, cyc_q[i].u, cyc_q[i].l} !== {e.d, e.u, e.l}) begin errors++; $display("[TB] FAIL basic_beat %0d: got d=%0d u=%b l=%b want d=%0d u=%b l=%b", hs, cyc_q[i].d, cyc_q[i].u, cyc_q[i].l, e.d, e.u, e.l); end
          if (cyc_q[i].r === 1'b1) begin prev_eof = e.eof; void'(exp_q.pop_front()); if (first_hs < 0) first_hs = i; last_hs = i; hs++; end
        end
      end
    end
    checks++; if (hs != 8 || exp_q.size() != 0) begin errors++; $display("[TB] FAIL basic_count: got %0d beats want 8", hs); end
    checks++; if (last_hs - first_hs != 7) begin errors++; $display("[TB] FAIL basic_throughput: got span %0d want 7", last_hs - first_hs); end
    checks++; if (t_first_v - t_acc != LAT * 10) begin errors++; $display("[TB] FAIL basic_latency: got %0t want %0d", t_first_v - t_acc, LAT * 10); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL basic_restart_busy: got %b want 1", busy); end
  endtask

  task automatic test_stall();
    int hs = 0;
    logic prev_eof = 1'b0;
    exp_t e;
    reset_dut();
    cfg_width = 11'd4; cfg_height = 11'd2; enable = 1'b1;
    fork
      drive(4, 2, 8, -1, 0, 1'b0, 0);
      collect(8, 1'b1);
    join
    foreach (cyc_q[i]) begin
      checks++;
      if (cyc_q[i].done !== prev_eof) begin errors++; $display("[TB] FAIL stall_frame_done cycle %0d: got %b want %b", i, cyc_q[i].done, prev_eof); end
      prev_eof = 1'b0;
      if (cyc_q[i].v === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("[TB] FAIL stall_extra_beat: got data %0d want none", cyc_q[i].d); end
        else begin
          e = exp_q[0];
          if ({cyc_q[i].d, cyc_q[i].u, cyc_q[i].l} !== {e.d, e.u, e.l}) begin errors++; $display("[TB] FAIL stall_beat %0d ready=%b: got d=%0d u=%b l=%b want d=%0d u=%b l=%b", hs, cyc_q[i].r, cyc_q[i].d, cyc_q[i].u, cyc_q[i].l, e.d, e.u, e.l); end
          if (cyc_q[i].r === 1'b1) begin prev_eof = e.eof; void'(exp_q.pop_front()); hs++; end
        end
      end
    end
    checks++; if (hs != 8 || exp_q.size() != 0) begin errors++; $display("[TB] FAIL stall_count: got %0d beats want 8", hs); end
  endtask

  task automatic test_enable_drop();
    int hs = 0;
    logic prev_eof = 1'b0;
    exp_t e;
    reset_dut();
    cfg_width = 11'd4; cfg_height = 11'd2; enable = 1'b1;
    fork
      drive(4, 2, 8, 3, 1, 1'b0, 0);
      collect(8, 1'b0);
    join
    foreach (cyc_q[i]) begin
      checks++;
      if (cyc_q[i].done !== prev_eof) begin errors++; $display("[TB] FAIL drop_frame_done cycle %0d: got %b want %b", i, cyc_q[i].done, prev_eof); end
      prev_eof = 1'b0;
      if (cyc_q[i].v === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("[TB] FAIL drop_extra_beat: got data %0d want none", cyc_q[i].d); end
        else begin
          e = exp_q[0];
          if ({cyc_q[i].d, cyc_q[i].u, cyc_q[i].l} !== {e.d, e.u, e.l}) begin errors++; $display("[TB] FAIL drop_beat %0d: got d=%0d u=%b l=%b want d=%0d u=%b l=%b", hs, cyc_q[i].d, cyc_q[i].u, cyc_q[i].l, e.d, e.u, e.l); end
          if (cyc_q[i].r === 1'b1) begin prev_eof = e.eof; void'(exp_q.pop_front()); hs++; end
        end
      end
    end
    checks++; if (hs != 8 || exp_q.size() != 0) begin errors++; $display("[TB] FAIL drop_count: got %0d beats want 8", hs); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL drop_busy: got %b want 0", busy); end
    checks++; if (s_pix_tready !== 1'b0) begin errors++; $display("[TB] FAIL drop_s_tready: got %b want 0", s_pix_tready); end
  endtask

  task automatic test_width_one();
    int hs = 0;
    logic prev_eof = 1'b0;
    exp_t e;
    reset_dut();
    cfg_width = 11'd1; cfg_height = 11'd3; enable = 1'b1;
    fork
      drive(1, 3, 3, 1, 1, 1'b0, 20);
      collect(3, 1'b0);
    join
    foreach (cyc_q[i]) begin
      checks++;
      if (cyc_q[i].done !== prev_eof) begin errors++; $display("[TB] FAIL w1_frame_done cycle %0d: got %b want %b", i, cyc_q[i].done, prev_eof); end
      prev_eof = 1'b0;
      if (cyc_q[i].v === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("[TB] FAIL w1_extra_beat: got data %0d want none", cyc_q[i].d); end
        else begin
          e = exp_q[0];
          if ({cyc_q[i].d, cyc_q[i].u, cyc_q[i].l} !== {e.d, e.u, e.l}) begin errors++; $display("[TB] FAIL w1_beat %0d: got d=%0d u=%b l=%b want d=%0d u=%b l=%b", hs, cyc_q[i].d, cyc_q[i].u, cyc_q[i].l, e.d, e.u, e.l); end
          if (cyc_q[i].r === 1'b1) begin prev_eof = e.eof; void'(exp_q.pop_front()); hs++; end
        end
      end
    end
    checks++; if (hs != 3 || exp_q.size() != 0) begin errors++; $display("[TB] FAIL w1_count: got %0d beats want 3", hs); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL w1_busy: got %b want 0", busy); end
  endtask

  task automatic test_width_zero();
    reset_dut();
    cfg_width = 11'd0; cfg_height = 11'd2; enable = 1'b1;
    s_pix_tvalid = 1'b1; s_pix_tdata = 8'd9;
    for (int i = 0; i < 6; i++) begin
      @(negedge aclk);
      checks++;
      if ({busy, s_pix_tready, m_axis_tvalid} !== 3'b000) begin errors++; $display("[TB] FAIL w0_idle cycle %0d: got busy/ready/valid=%b want 000", i, {busy, s_pix_tready, m_axis_tvalid}); end
    end
    s_pix_tvalid = 1'b0; enable = 1'b0;
  endtask

  task automatic test_reset_mid();
    int hs = 0;
    logic prev_eof = 1'b0;
    exp_t e;
    reset_dut();
    cfg_width = 11'd4; cfg_height = 11'd4; enable = 1'b1;
    drive(4, 4, 5, -1, 0, 1'b0, 0);
    #2;
    aresetn = 1'b0;
    #1;
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_tvalid: got %b want 0", m_axis_tvalid); end
    checks++; if (m_axis_tdata !== 8'd0) begin errors++; $display("[TB] FAIL midrst_tdata: got %0d want 0", m_axis_tdata); end
    checks++; if ({busy, s_pix_tready} !== 2'b00) begin errors++; $display("[TB] FAIL midrst_busy_ready: got %b want 00", {busy, s_pix_tready}); end
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    exp_q.delete();
    fork
      drive(4, 4, 16, 15, 1, 1'b1, 100);
      collect(16, 1'b1);
    join
    foreach (cyc_q[i]) begin
      checks++;
      if (cyc_q[i].done !== prev_eof) begin errors++; $display("[TB] FAIL midrst_frame_done cycle %0d: got %b want %b", i, cyc_q[i].done, prev_eof); end
      prev_eof = 1'b0;
      if (cyc_q[i].v === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("[TB] FAIL midrst_extra_beat: got data %0d want none", cyc_q[i].d); end
        else begin
          e = exp_q[0];
          if ({cyc_q[i].d, cyc_q[i].u, cyc_q[i].l} !== {e.d, e.u, e.l}) begin errors++; $display("[TB] FAIL midrst_beat %0d: got d=%0d u=%b l=%b want d=%0d u=%b l=%b", hs, cyc_q[i].d, cyc_q[i].u, cyc_q[i].l, e.d, e.u, e.l); end
          if (cyc_q[i].r === 1'b1) begin prev_eof = e.eof; void'(exp_q.pop_front()); hs++; end
        end
      end
    end
    checks++; if (hs != 16 || exp_q.size() != 0) begin errors++; $display("[TB] FAIL midrst_count: got %0d beats want 16", hs); end
  endtask

  task automatic test_back_to_back();
    int hs = 0, first_hs = -1, last_hs = -1;
    logic prev_eof = 1'b0;
    exp_t e;
    reset_dut();
    cfg_width = 11'd3; cfg_height = 11'd2; enable = 1'b1;
    fork
      begin
        drive(3, 2, 6, 2, 2, 1'b0, 0);
        drive(2, 2, 4, -1, 0, 1'b0, 50);
      end
      collect(10, 1'b0);
    join
    foreach (cyc_q[i]) begin
      checks++;
      if (cyc_q[i].done !== prev_eof) begin errors++; $display("[TB] FAIL b2b_frame_done cycle %0d: got %b want %b", i, cyc_q[i].done, prev_eof); end
      prev_eof = 1'b0;
      if (cyc_q[i].v === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("[TB] FAIL b2b_extra_beat: got data %0d want none", cyc_q[i].d); end
        else begin
          e = exp_q[0];
          if ({cyc_q[i].d, cyc_q[i].u, cyc_q[i].l} !== {e.d, e.u, e.l}) begin errors++; $display("[TB] FAIL b2b_beat %0d: got d=%0d u=%b l=%b want d=%0d u=%b l=%b", hs, cyc_q[i].d, cyc_q[i].u, cyc_q[i].l, e.d, e.u, e.l); end
          if (cyc_q[i].r === 1'b1) begin prev_eof = e.eof; void'(exp_q.pop_front()); if (first_hs < 0) first_hs = i; last_hs = i; hs++; end
        end
      end
    end
    checks++; if (hs != 10 || exp_q.size() != 0) begin errors++; $display("[TB] FAIL b2b_count: got %0d beats want 10", hs); end
    checks++; if (last_hs - first_hs != 9) begin errors++; $display("[TB] FAIL b2b_bubble: got span %0d want 9", last_hs - first_hs); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_enable_drop();
    test_width_one();
    test_width_zero();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fractal_stream_framer.md
FRACTAL_STREAM_FRAMER -- requirements
Module: fractal_stream_framer

Interface
REQ-001 SHALL have parameter X_BITS, default 11, width of the line-length and column counters.
REQ-002 SHALL have parameter Y_BITS, default 11, width of the frame-height and row counters.
REQ-003 SHALL have port aclk, input, 1, the single clock for all logic.
REQ-004 SHALL have port aresetn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port enable, input, 1, run frames while high.
REQ-006 SHALL have port cfg_width, input, X_BITS, pixels per line.
REQ-007 SHALL have port cfg_height, input, Y_BITS, lines per frame.
REQ-008 SHALL have ports s_pix_tvalid (input, 1), s_pix_tdata (input, 8) and s_pix_tready (output, 1), forming the upstream pixel stream of iteration values.
REQ-009 SHALL have ports m_axis_tvalid (output, 1), m_axis_tdata (output, 8), m_axis_tstrb (output, 1), m_axis_tuser (output, 1), m_axis_tlast (output, 1) and m_axis_tready (input, 1), forming the AXI4-Stream video output.
REQ-010 SHALL have port busy, output, 1, high while in RUN.
REQ-011 SHALL have port frame_done, output, 1, one-cycle pulse when the last pixel of a frame is accepted downstream.

Function
REQ-012 States SHALL be IDLE and RUN.
REQ-013 IDLE SHALL go to RUN when enable=1, cfg_width!=0 and cfg_height!=0; cfg_width and cfg_height SHALL be latched on that transition.
REQ-014 In IDLE s_pix_tready SHALL be 0 and no pixel SHALL be accepted.
REQ-015 In RUN an input pixel SHALL be accepted on each cycle with s_pix_tvalid & s_pix_tready, tagged with the current column x and row y.
REQ-016 x SHALL increment per accepted pixel and wrap to 0 after latched_width-1, at which point y increments.
REQ-017 tuser SHALL be 1 only on the pixel with x=0, y=0; tlast SHALL be 1 only on pixels with x=latched_width-1; width 1 gives tlast on every pixel.
REQ-018 m_axis_tstrb SHALL be constant 1.
REQ-019 On accepting the pixel with x=latched_width-1 and y=latched_height-1, counters SHALL clear; with enable=1 the next frame SHALL start with relatched config and no bubble, otherwise the block SHALL go to IDLE.
REQ-020 Deasserting enable mid-frame SHALL NOT truncate the frame: the frame SHALL complete, then the block SHALL go to IDLE.
REQ-021 Config changes during RUN SHALL have no effect until the next frame start.
REQ-022 Output beats SHALL hold all fields stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-023 Output order SHALL equal input order; no pixel SHALL be dropped or duplicated.
REQ-024 frame_done SHALL pulse in the cycle after the tlast beat of the final line completes its handshake.

Reset
REQ-025 On aresetn=0, regardless of clock: state IDLE, x=y=0, buffer empty, m_axis_tvalid=0, m_axis_tuser=0, m_axis_tlast=0, m_axis_tdata=0, s_pix_tready=0, busy=0, frame_done=0.
REQ-026 Reset mid-frame SHALL discard buffered pixels; after release the next frame SHALL start with tuser=1.

Configuration
REQ-027 With FRACTAL_FRAMER_FIFO_EN defined, a 16-entry FIFO SHALL sit between acceptance and output: s_pix_tready=RUN & !fifo_full, and first-beat latency SHALL be 2 cycles.
REQ-028 Without FRACTAL_FRAMER_FIFO_EN, a 2-entry skid buffer SHALL be used: s_pix_tready SHALL be registered, latency SHALL be 1 cycle, and throughput SHALL be 1 pixel/cycle under continuous tready.

Structure
REQ-029 fractal_pkg SHALL hold the state enum, the beat struct {tdata, tuser, tlast}, and the FIFO depth constant 16.
REQ-030 The buffer SHALL be a sub-module fractal_stream_fifo, parameterised by depth (2 gives the skid variant).

Verification
REQ-031 Frame 4x2, data 0..7, tready=1 -> 8 beats, tuser on beat 0, tlast on beats 3 and 7, frame_done one cycle after beat 7.
REQ-032 Same frame with tready toggling 1010... -> identical beat sequence, all fields stable while stalled.
REQ-033 enable dropped after pixel 2 of a 4x2 frame -> all 8 beats emitted, then busy=0 and s_pix_tready=0.
REQ-034 cfg_width=1, cfg_height=3 -> 3 beats, each tlast=1, tuser only on the first.
REQ-035 cfg_width=0 with enable=1 -> stays IDLE, no beats, busy=0.
REQ-036 aresetn pulsed after 5 pixels of a 4x4 frame -> outputs reset immediately; the next frame starts with tuser=1 and x=0.
